instr_encoder_loader: RTL and testbench

//  Inverse of the control decoder: accepts decoded instruction fields over a valid/ready

---
 rtl/instr_encoder_loader_pkg.sv | 60 ++++++
 rtl/instr_word_fifo.sv | 51 +++++
 rtl/instr_encoder_loader.sv | 143 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: MIPS opcode
// constants, instruction format classes, the request bundle, the FIFO entry
// layout and the field-assembly helpers used by the loader top.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_CP1    = 6'h11;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LWC1   = 6'h31;
  localparam logic [5:0] OP_SWC1   = 6'h39;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} fmt_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } req_t;

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } fifo_ent_t;

  function automatic fmt_e op_fmt(input logic [5:0] op);
    case (op)
      OP_R_TYPE, OP_CP1: return FMT_R;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LWC1, OP_SWC1: return FMT_I;
      OP_J: return FMT_J;
      default: return FMT_ILL;
    endcase
  endfunction

  // LUI has no source register; rs is forced to zero so the word is canonical.
  function automatic logic [31:0] encode(input req_t r);
    case (op_fmt(r.opcode))
      FMT_R:   return {r.opcode, r.rs, r.rt, r.rd, r.shamt, r.funct};
      FMT_I:   return {r.opcode, (r.opcode == OP_LUI) ? 5'd0 : r.rs, r.rt, r.imm};
      FMT_J:   return {r.opcode, r.target};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Small synchronous FIFO holding encoded instruction words plus their
// end-of-program flag.
//  clk, rst_n      clock / async active-low reset (pointers and count only)
//  push, din       write an entry (caller guarantees !full)
//  pop             drop the head entry (caller guarantees !empty)
//  dout            head entry, valid while !empty
//  full, empty     occupancy flags; count gives exact occupancy
module instr_word_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Assembles decoded instruction fields into 32-bit MIPS words and writes them
// sequentially into instruction memory.
//  load_start/base_addr   arm the loader at a word-aligned base address
//  req_*                  valid/ready field bundle; req_last ends the program
//  imem_we/addr/wdata     write request, held stable until imem_ack
//  busy, done             armed-and-running / one-cycle completion pulse
//  word_count             words acked since load_start (saturating)
//  err_illegal            sticky flag for unsupported opcodes
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic              err_illegal
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              last_seen;
  req_t              req;
  fifo_ent_t         push_ent, head;
  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic              accept, legal, push, ack, start;

  always_comb begin
    req        = '0;
    req.opcode = req_opcode;
    req.rs     = req_rs;
    req.rt     = req_rt;
    req.rd     = req_rd;
    req.shamt  = req_shamt;
    req.funct  = req_funct;
    req.imm    = req_imm;
    req.target = req_target;
    req.last   = req_last;
  end

  assign busy      = (state == S_ARMED) || (state == S_WRITE);
  // Deliberately ignores a same-cycle pop: no full-bypass path.
  assign req_ready = busy && !fifo_full && !last_seen;
  assign accept    = req_valid && req_ready;
  assign legal     = (op_fmt(req.opcode) != FMT_ILL);
  assign push      = accept && legal;
  assign ack       = (state == S_WRITE) && imem_ack;
  assign start     = load_start && ((state == S_IDLE) || (state == S_DONE));

  assign push_ent.last = req.last;
  assign push_ent.word = encode(req);

  instr_word_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fifo_ent_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_ent),
    .pop   (ack),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = addr;
  assign imem_wdata = imem_we ? head.word : 32'd0;
  assign done       = (state == S_DONE);

  // ARMED looks at the incoming push so the first write starts the cycle
  // after acceptance. After an ack, WRITE continues without a bubble when
  // anything is left (or arriving); otherwise an end marker finishes the run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ARMED;
      S_ARMED: begin
        if (!fifo_empty || push) state_nxt = S_WRITE;
        else if (last_seen)      state_nxt = S_DONE;
      end
      S_WRITE: begin
        if (ack) begin
          if ((fifo_count > FCW'(1)) || push) state_nxt = S_WRITE;
          else if (head.last || last_seen)    state_nxt = S_DONE;
          else                                state_nxt = S_ARMED;
        end
      end
      default: state_nxt = start ? S_ARMED : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      last_seen   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr        <= base_addr & ~ADDR_W'(3);
        word_count  <= '0;
        err_illegal <= 1'b0;
        last_seen   <= 1'b0;
      end else begin
        if (ack) begin
          addr <= addr + ADDR_W'(4);
          if (word_count != '1) word_count <= word_count + CNT_W'(1);
        end
        if (accept && !legal)   err_illegal <= 1'b1;
        if (accept && req_last) last_seen   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [31:0] base_addr;
  logic        req_valid, req_ready;
  logic [5:0]  req_opcode, req_funct;
  logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        req_last;
  logic        imem_we, imem_ack;
  logic [31:0] imem_addr, imem_wdata;
  logic        busy, done, err_illegal;
  logic [15:0] word_count;

  instr_encoder_loader #(.ADDR_W(32), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt),
    .req_funct(req_funct), .req_imm(req_imm), .req_target(req_target),
    .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ack(imem_ack), .busy(busy), .done(done),
    .word_count(word_count), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_ack_cyc = 0, ack_gap = 0;
  logic hold_pend = 1'b0, prev_done = 1'b0;
  logic [31:0] hold_a, hold_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every acked write against the scoreboard, checks that a
  // stalled write holds its address/data and that done is a single pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      hold_pend = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_we", imem_we, 1);
        chk("hold_addr", imem_addr, hold_a);
        chk("hold_data", imem_wdata, hold_d);
      end
      hold_pend = imem_we && !imem_ack;
      hold_a = imem_addr;
      hold_d = imem_wdata;
      if (imem_we && imem_ack) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", imem_addr, e.a);
          chk("wr_data", imem_wdata, e.d);
        end
        ack_gap = cyc - last_ack_cyc;
        last_ack_cyc = cyc;
      end
      if (done) chk("done_single_pulse", prev_done, 0);
      prev_done = done;
    end
  end

  task automatic load(input logic [31:0] b);
    base_addr = b; load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input logic has_exp, input logic [31:0] ea, input logic [31:0] ed);
    int n;
    if (has_exp) exp_q.push_back('{a: ea, d: ed});
    req_opcode = op; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh;
    req_funct = fn; req_imm = imm; req_target = tgt; req_last = last; req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 300);
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_timeout: ready %0b expected 1", req_ready);
    end
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_cnt);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_done_timeout: done %0b expected 1", name, done);
    end else begin
      chk({name, "_count"}, word_count, exp_cnt);
      chk({name, "_busy"}, busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; base_addr = '0; req_valid = 1'b0;
    req_opcode = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0;
    req_funct = '0; req_imm = '0; req_target = '0; req_last = 1'b0; imem_ack = 1'b1;
    #12;
    chk("rst_we", imem_we, 0);      chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);       chk("rst_count", word_count, 0);
    chk("rst_err", err_illegal, 0); chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single ADDI, low base bits ignored
    load(32'h0000_0403);
    send(6'h08, 0, 8, 0, 0, 0, 16'h0005, 0, 1, 1, 32'h400, 32'h2008_0005);
    wait_done("t1", 1);

    // 2: R-type then J, back-to-back
    load(32'h0000_1000);
    send(6'h00, 9, 10, 8, 0, 6'h20, 0, 0, 0, 1, 32'h1000, 32'h012A_4020);
    send(6'h02, 0, 0, 0, 0, 0, 0, 26'h010_0000, 1, 1, 32'h1004, 32'h0810_0000);
    wait_done("t2", 2);
    chk("t2_no_bubble", ack_gap, 1);

    // 3: LUI with nonzero rs
    load(32'h0000_2000);
    send(6'h0F, 7, 1, 0, 0, 0, 16'h1234, 0, 1, 1, 32'h2000, 32'h3C01_1234);
    wait_done("t3", 1);

    // 4: illegal opcode, then a legal ORI at the unchanged address
    load(32'h0000_3000);
    send(6'h3F, 1, 2, 3, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    chk("t4_err", err_illegal, 1);
    chk("t4_count", word_count, 0);
    chk("t4_we", imem_we, 0);
    send(6'h0D, 2, 3, 0, 0, 0, 16'hBEEF, 0, 1, 1, 32'h3000, 32'h3443_BEEF);
    wait_done("t4", 1);
    chk("t4_err_sticky", err_illegal, 1);

    // 4b: illegal opcode carrying last -> done with nothing written; err cleared on start
    load(32'h0000_3800);
    chk("t4b_err_clear", err_illegal, 0);
    send(6'h3F, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    wait_done("t4b", 0);

    // 5: memory stalls while FIFO_DEPTH+2 requests are offered
    imem_ack = 1'b0;
    load(32'h0000_5000);
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(6'h08, 0, 8, 0, 0, 0, 16'(i), 0, (i == 5), 1,
               32'h5000 + 32'(4 * i), 32'h2008_0000 + 32'(i));
      end
    join_none
    repeat (8) @(negedge clk);
    chk("t5_ready_full", req_ready, 0);
    chk("t5_we", imem_we, 1);
    chk("t5_addr", imem_addr, 32'h5000);
    chk("t5_data", imem_wdata, 32'h2008_0000);
    @(posedge clk); #1 imem_ack = 1'b1;
    wait_done("t5", 6);
    chk("t5_all_written", exp_q.size(), 0);

    // 6: async reset in the middle of a stalled write
    imem_ack = 1'b0;
    load(32'h0000_6000);
    send(6'h08, 0, 8, 0, 0, 0, 16'h0009, 0, 1, 1, 32'h6000, 32'h2008_0009);
    chk("t6_we_before", imem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_we", imem_we, 0);       chk("t6_addr", imem_addr, 0);
    chk("t6_wdata", imem_wdata, 0); chk("t6_busy", busy, 0);
    chk("t6_count", word_count, 0); chk("t6_ready", req_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1; imem_ack = 1'b1;
    @(posedge clk); #1;
    load(32'h0000_7000);
    chk("t6_restart_count", word_count, 0);
    send(6'h08, 0, 8, 0, 0, 0, 16'h0007, 0, 1, 1, 32'h7000, 32'h2008_0007);
    wait_done("t6", 1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
